// File: rtl/matvec_pkg.sv
// matvec_pkg: shared widths, FIFO entry type and the requantization function.
package matvec_pkg;
    localparam int K = 8;
    localparam int IN_W = 28;
    localparam int OUT_W = 14;
    localparam logic signed [IN_W:0] QMAX = (IN_W+1)'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [IN_W:0] QMIN = -QMAX - (IN_W+1)'(1);

    typedef struct packed {
        logic             last;
        logic [OUT_W-1:0] data;
    } req_entry_t;

    typedef struct packed {
        logic             clipped;
        logic [OUT_W-1:0] data;
    } requant_t;

    // One extra bit of headroom keeps the rounding add from overflowing.
    function automatic requant_t requant(input logic [IN_W-1:0] x, input int shift, input logic relu);
        logic signed [IN_W:0] r;
        logic signed [IN_W:0] rnd;
        requant_t q;
        r = (relu && x[IN_W-1]) ? '0 : $signed({x[IN_W-1], x});
        if (shift > 0) begin
            rnd = (IN_W+1)'(1) <<< (shift - 1);
            r = (r + rnd) >>> shift;
        end
        q.clipped = (r > QMAX) || (r < QMIN);
        q.data = r > QMAX ? QMAX[OUT_W-1:0] : r < QMIN ? QMIN[OUT_W-1:0] : r[OUT_W-1:0];
        return q;
    endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with registered count; pointers wrap modulo DEPTH.
module sync_fifo #(
    parameter int WIDTH = 15,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             do_push, do_pop;

    always_comb begin
        empty = count == '0;
        full = count == (AW+1)'(DEPTH);
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        rdata = mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/matvec_requant8.sv
// matvec_requant8: ReLU/round/saturate a matvec result stream into a 14-bit stream
// with per-vector last flag, buffered through a small FIFO.
module matvec_requant8 #(
    parameter int K = matvec_pkg::K,
    parameter int IN_W = matvec_pkg::IN_W,
    parameter int OUT_W = matvec_pkg::OUT_W,
    parameter int SHIFT = 7,
    parameter bit RELU = 1'b1,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             input_valid,
    output logic             input_ready,
    input  logic [IN_W-1:0]  input_data,
    output logic             output_valid,
    input  logic             output_ready,
    output logic [OUT_W-1:0] output_data,
    output logic             output_last,
    output logic [15:0]      sat_count
);
    import matvec_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int IW = K > 1 ? $clog2(K) : 1;

    req_entry_t    s1_entry, rd_entry;
    requant_t      q;
    logic          s1_valid, s1_clip;
    logic [IW-1:0] idx;
    logic [AW:0]   count, occ;
    logic          empty, full, in_fire, push, pop;

    // Ready depends only on registered occupancy, never on output_ready.
    always_comb begin
        occ = count + (AW+1)'(s1_valid);
        input_ready = !reset && occ < (AW+1)'(DEPTH);
        in_fire = input_valid && input_ready;
        pop = output_ready && !empty;
        push = s1_valid && (!full || pop);
        q = requant(input_data, SHIFT, RELU);
        output_valid = !empty;
        output_data = empty ? '0 : rd_entry.data;
        output_last = !empty && rd_entry.last;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            idx <= '0;
            sat_count <= '0;
        end else begin
            if (in_fire) begin
                s1_valid <= 1'b1;
                idx <= idx == IW'(K - 1) ? '0 : idx + 1'b1;
            end else if (push) begin
                s1_valid <= 1'b0;
            end
            if (push && s1_clip && sat_count != 16'hFFFF) sat_count <= sat_count + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_entry <= '{last: idx == IW'(K - 1), data: q.data};
            s1_clip <= q.clipped;
        end
    end

    sync_fifo #(
        .WIDTH($bits(req_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (s1_entry),
        .rdata (rd_entry),
        .count (count),
        .empty (empty),
        .full  (full)
    );
endmodule
